// File: rtl/led_s2p_rx_pkg.sv
// Shared types and constants for the LED shift-chain receiver.
package led_s2p_rx_pkg;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      FULL    = 2'd2,
      OVERRUN = 2'd3
   } state_t;

   localparam int DIR_MSB_FIRST = 0;
   localparam int DIR_LSB_FIRST = 1;
endpackage

// File: rtl/led_s2p_rx_if.sv
// LED chain wires (transmitter side) plus the recovered parallel word.
interface led_s2p_rx_if #(parameter int DATA_BITS = 16);
   logic                 sclk;
   logic                 sclrn;
   logic                 sin;
   logic                 latch;
   logic [DATA_BITS-1:0] pdata;
   logic                 valid;
   logic                 frame_err;
   logic                 busy;

   modport master (output sclk, sclrn, sin, latch,
                   input  pdata, valid, frame_err, busy);
   modport slave  (input  sclk, sclrn, sin, latch,
                   output pdata, valid, frame_err, busy);
endinterface

// File: rtl/led_s2p_rx_sync_edge_det.sv
// Multi-flop synchronizer with a history flop for rising-edge detection.
module sync_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_out,
   output logic rise
);
   logic [SYNC_STAGES-1:0] stg;
   logic                   hist;

   always_ff @(posedge clk) begin
      if (rst) begin
         stg  <= '0;
         hist <= 1'b0;
      end else begin
         stg  <= {stg[SYNC_STAGES-2:0], async_in};
         hist <= stg[SYNC_STAGES-1];
      end
   end

   assign sync_out = stg[SYNC_STAGES-1];
   assign rise     = stg[SYNC_STAGES-1] & ~hist;
endmodule

// File: rtl/led_s2p_rx.sv
// Far-end receiver of the 4-wire LED chain: shift register, bit counter, framing FSM.
// Build option: define LED_S2P_INVERT_EN to capture the inverted shift register.
module led_s2p_rx
   import led_s2p_rx_pkg::*;
#(
   parameter int DATA_BITS       = 16,
   parameter int DATA_COUNT_BITS = 5,
   parameter int DIR             = 0,
   parameter int SYNC_STAGES     = 2
) (
   input logic         clk,
   input logic         rst,
   led_s2p_rx_if.slave bus
);
   localparam logic [DATA_COUNT_BITS-1:0] FULL_CNT = DATA_COUNT_BITS'(DATA_BITS);

   localparam int W_SCLK  = 0;
   localparam int W_SCLRN = 1;
   localparam int W_SIN   = 2;
   localparam int W_LATCH = 3;

   logic [3:0] raw, syn, rise;
   logic       unused_edges;

   assign raw = {bus.latch, bus.sin, bus.sclrn, bus.sclk};

   // All four wires share the same depth so sin stays aligned with the sclk edge.
   for (genvar i = 0; i < 4; i++) begin : g_sync
      sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk     (clk),
         .rst     (rst),
         .async_in(raw[i]),
         .sync_out(syn[i]),
         .rise    (rise[i])
      );
   end

   assign unused_edges = &{1'b0, rise[W_SCLRN], rise[W_SIN], syn[W_SCLK], syn[W_LATCH]};

   logic sclk_rise, latch_rise, sclrn_s, sin_s;
   assign sclk_rise  = rise[W_SCLK];
   assign latch_rise = rise[W_LATCH];
   assign sclrn_s    = syn[W_SCLRN];
   assign sin_s      = syn[W_SIN];

   state_t                     state, state_nxt, sh_state;
   logic [DATA_BITS-1:0]       sreg, sreg_nxt, sh_sreg, cap;
   logic [DATA_COUNT_BITS-1:0] cnt, cnt_nxt, sh_cnt;
   logic [DATA_BITS-1:0]       pdata_q;
   logic                       valid_q, err_q;
   logic                       take_word, bad_frame;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sreg  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         sreg  <= sreg_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Shift is resolved first so a coincident latch judges the post-shift frame.
   always_comb begin
      sh_sreg  = sreg;
      sh_cnt   = cnt;
      sh_state = state;
      if (sclk_rise) begin
         if (DIR == DIR_MSB_FIRST) sh_sreg = DATA_BITS'({sreg, sin_s});
         else                      sh_sreg = DATA_BITS'({sin_s, sreg} >> 1);
         if (cnt != FULL_CNT) sh_cnt = cnt + 1'b1;
         case (state)
            IDLE:    sh_state = (DATA_BITS == 1) ? FULL : SHIFT;
            SHIFT:   sh_state = (cnt + 1'b1 == FULL_CNT) ? FULL : SHIFT;
            default: sh_state = OVERRUN;
         endcase
      end

      sreg_nxt  = sh_sreg;
      cnt_nxt   = sh_cnt;
      state_nxt = sh_state;
      if (!sclrn_s) begin
         sreg_nxt  = '0;
         cnt_nxt   = '0;
         state_nxt = IDLE;
      end else if (latch_rise) begin
         cnt_nxt   = '0;
         state_nxt = IDLE;
      end
   end

   always_comb begin
      take_word = sclrn_s & latch_rise & (sh_state == FULL);
      bad_frame = sclrn_s & latch_rise & (sh_state != FULL);
`ifdef LED_S2P_INVERT_EN
      cap = ~sh_sreg;
`else
      cap = sh_sreg;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pdata_q <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= take_word;
         err_q   <= bad_frame;
         if (take_word) pdata_q <= cap;
      end
   end

   assign bus.pdata     = pdata_q;
   assign bus.valid     = valid_q;
   assign bus.frame_err = err_q;
   assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_led_s2p_rx.sv
// Directed bench for led_s2p_rx: frames, short/long frames, clear, reset, loopback latency.
module tb_led_s2p_rx;
   import led_s2p_rx_pkg::*;

   localparam int DB = 16;
   localparam int SS = 2;

   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   led_s2p_rx_if #(.DATA_BITS(DB)) bus ();

   led_s2p_rx #(.DATA_BITS(DB), .DATA_COUNT_BITS(5), .DIR(0), .SYNC_STAGES(SS)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic wait_neg(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // sclk low/high 4 clk periods each, sin set while sclk low.
   task automatic send_bit(input logic b);
      bus.sin  = b;
      wait_neg(4);
      bus.sclk = 1'b1;
      wait_neg(4);
      bus.sclk = 1'b0;
   endtask

   task automatic send_word(input logic [DB-1:0] w);
      for (int i = DB - 1; i >= 0; i--) send_bit(w[i]);
      wait_neg(2);
   endtask

   // lat: index of the edge where valid/frame_err is first seen, edge 1 = first edge sampling latch high.
   task automatic do_latch(output int v, output int e, output int both, output int lat);
      v = 0; e = 0; both = 0; lat = 0;
      @(negedge clk);
      bus.latch = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk);
         #1;
         if (bus.valid) v++;
         if (bus.frame_err) e++;
         if (bus.valid && bus.frame_err) both++;
         if ((bus.valid || bus.frame_err) && lat == 0) lat = i;
         if (i == 5) bus.latch = 1'b0;
      end
      wait_neg(4);
   endtask

   task automatic test_reset;
      rst = 1'b1; bus.sclk = 1'b0; bus.sclrn = 1'b1; bus.sin = 1'b0; bus.latch = 1'b0;
      wait_neg(4);
      vectors++; if (bus.pdata !== 16'h0) begin miscompares++; $display("FAIL reset_pdata got %h exp 0000", bus.pdata); end
      vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", bus.valid); end
      vectors++; if (bus.frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", bus.frame_err); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      rst = 1'b0;
      wait_neg(4);
   endtask

   task automatic test_full_frame;
      int v, e, b, l;
      send_word(16'hA55A);
      vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL full_busy got %b exp 1", bus.busy); end
      do_latch(v, e, b, l);
      vectors++; if (bus.pdata !== 16'hA55A) begin miscompares++; $display("FAIL full_pdata got %h exp a55a", bus.pdata); end
      vectors++; if (v !== 1) begin miscompares++; $display("FAIL full_valid_cycles got %0d exp 1", v); end
      vectors++; if (e !== 0) begin miscompares++; $display("FAIL full_err_cycles got %0d exp 0", e); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL full_busy_after got %b exp 0", bus.busy); end
   endtask

   task automatic test_short_frame;
      int v, e, b, l;
      for (int i = 0; i < 15; i++) send_bit(i[0]);
      wait_neg(2);
      do_latch(v, e, b, l);
      vectors++; if (e !== 1) begin miscompares++; $display("FAIL short_err_cycles got %0d exp 1", e); end
      vectors++; if (v !== 0) begin miscompares++; $display("FAIL short_valid_cycles got %0d exp 0", v); end
      vectors++; if (bus.pdata !== 16'hA55A) begin miscompares++; $display("FAIL short_pdata got %h exp a55a", bus.pdata); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL short_busy got %b exp 0", bus.busy); end
   endtask

   task automatic test_overrun;
      int v, e, b, l;
      for (int i = 0; i < 16; i++) send_bit(1'b1);
      wait_neg(2);
      vectors++; if (dut.state !== FULL) begin miscompares++; $display("FAIL ovr_state16 got %0d exp 2", dut.state); end
      send_bit(1'b0);
      wait_neg(2);
      vectors++; if (dut.state !== OVERRUN) begin miscompares++; $display("FAIL ovr_state17 got %0d exp 3", dut.state); end
      do_latch(v, e, b, l);
      vectors++; if (e !== 1) begin miscompares++; $display("FAIL ovr_err_cycles got %0d exp 1", e); end
      vectors++; if (v !== 0) begin miscompares++; $display("FAIL ovr_valid_cycles got %0d exp 0", v); end
      vectors++; if (bus.pdata !== 16'hA55A) begin miscompares++; $display("FAIL ovr_pdata got %h exp a55a", bus.pdata); end
   endtask

   task automatic test_clear;
      int v, e, b, l;
      for (int i = 0; i < 8; i++) send_bit(1'b1);
      wait_neg(2);
      bus.sclrn = 1'b0;
      wait_neg(4);
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL clr_busy got %b exp 0", bus.busy); end
      vectors++; if (dut.sreg !== 16'h0) begin miscompares++; $display("FAIL clr_sreg got %h exp 0000", dut.sreg); end
      bus.sclrn = 1'b1;
      wait_neg(4);
      send_word(16'h1234);
      do_latch(v, e, b, l);
      vectors++; if (bus.pdata !== 16'h1234) begin miscompares++; $display("FAIL clr_pdata got %h exp 1234", bus.pdata); end
      vectors++; if (v !== 1) begin miscompares++; $display("FAIL clr_valid_cycles got %0d exp 1", v); end
      vectors++; if (e !== 0) begin miscompares++; $display("FAIL clr_err_cycles got %0d exp 0", e); end
   endtask

   task automatic test_reset_mid;
      int v, e, b, l;
      for (int i = 0; i < 10; i++) send_bit(i[1]);
      rst = 1'b1;
      wait_neg(3);
      vectors++; if (bus.pdata !== 16'h0) begin miscompares++; $display("FAIL rstm_pdata got %h exp 0000", bus.pdata); end
      vectors++; if (bus.valid !== 1'b0 || bus.frame_err !== 1'b0) begin
         miscompares++; $display("FAIL rstm_pulses got v=%b e=%b exp 0 0", bus.valid, bus.frame_err); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rstm_busy got %b exp 0", bus.busy); end
      rst = 1'b0;
      wait_neg(4);
      send_word(16'hFFFF);
      do_latch(v, e, b, l);
      vectors++; if (bus.pdata !== 16'hFFFF) begin miscompares++; $display("FAIL rstm_pdata2 got %h exp ffff", bus.pdata); end
      vectors++; if (v !== 1 || e !== 0) begin miscompares++; $display("FAIL rstm_pulses2 got v=%0d e=%0d exp 1 0", v, e); end
   endtask

   // Transmitter inverts LED data on the wire.
   task automatic test_loopback;
      int v, e, b, l;
      logic [DB-1:0] led, expw;
      led = 16'h002A;
`ifdef LED_S2P_INVERT_EN
      expw = 16'h002A;
`else
      expw = 16'hFFD5;
`endif
      send_word(~led);
      do_latch(v, e, b, l);
      vectors++; if (bus.pdata !== expw) begin miscompares++; $display("FAIL lb_pdata got %h exp %h", bus.pdata, expw); end
      vectors++; if (v !== 1 || b !== 0) begin miscompares++; $display("FAIL lb_valid got v=%0d both=%0d exp 1 0", v, b); end
      vectors++; if (l !== SS + 1) begin miscompares++; $display("FAIL lb_latency got %0d exp %0d", l, SS + 1); end
      // Latch with an empty chain is a zero-length frame.
      do_latch(v, e, b, l);
      vectors++; if (e !== 1 || v !== 0) begin miscompares++; $display("FAIL idle_latch got v=%0d e=%0d exp 0 1", v, e); end
      vectors++; if (bus.pdata !== expw) begin miscompares++; $display("FAIL idle_pdata got %h exp %h", bus.pdata, expw); end
      vectors++; if (l !== SS + 1) begin miscompares++; $display("FAIL err_latency got %0d exp %0d", l, SS + 1); end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_short_frame();
      test_overrun();
      test_clear();
      test_reset_mid();
      test_loopback();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/led_s2p_rx.md
Name: led_s2p_rx

Overview:
- Serial-to-parallel receiver for the 4-wire LED shift-chain protocol: sclk, sclrn, sout, EN/latch.
- Models the far end of the chain, i.e. the 74HC164-style register plus output latch.
- Oversamples the protocol wires with the system clock and reassembles DATA_BITS-wide words.
- Used as a loopback checker and as a readback path for GPIO LED data; reports framing errors.

Parameters:
- DATA_BITS, 16, word width; also the exact number of sclk rising edges per frame.
- DATA_COUNT_BITS, 5, bit-counter width; must satisfy 2^DATA_COUNT_BITS > DATA_BITS.
- DIR, 0, shift direction. 0: shift left, first bit received ends in MSB. 1: shift right, first bit received ends in LSB.
- SYNC_STAGES, 2, synchronizer depth on each input wire; minimum 2.

Ports:
- clk  input  1  system clock; all flops on posedge.
- rst  input  1  synchronous, active-high reset.
- sclk  input  1  serial shift clock from the transmitter; asynchronous to clk.
- sclrn  input  1  active-low chain clear from the transmitter.
- sin  input  1  serial data from the transmitter.
- latch  input  1  transmitter EN; rising edge commits the frame.
- pdata  output  DATA_BITS  last committed word.
- valid  output  1  one-cycle pulse when pdata updates.
- frame_err  output  1  one-cycle pulse on a latch with a bad bit count.
- busy  output  1  high while the receive FSM is not IDLE.

Behaviour:
- Reset (rst high at posedge clk) sets:
  - pdata = 0, valid = 0, frame_err = 0, busy = 0.
  - shift register = 0, bit count = 0, state = IDLE.
  - all synchronizer and edge-history flops = 0.
- Reset mid-frame discards the partial frame; no valid or frame_err is issued.
- Synchronization and edge detection:
  - sclk, sclrn, sin and latch each pass through SYNC_STAGES flops.
  - A rising edge is detected when the synchronized value is 1 and its previous value was 0.
  - sin is sampled from the same synchronizer stage as sclk, so the data/clock relationship is preserved.
- Timing requirement: sclk high and low each last at least SYNC_STAGES+1 clk periods. Faster sclk is unsupported and unchecked.
- Shift on a detected sclk rise:
  - DIR 0: sreg = {sreg[DATA_BITS-2:0], sin}.
  - DIR 1: sreg = {sin, sreg[DATA_BITS-1:1]}.
  - The count increments and saturates at DATA_BITS.
- Clear: synchronized sclrn low clears sreg and count and forces IDLE. It takes priority over a sclk rise in the same cycle.
- FSM states:
  - IDLE (count 0): sclk rise → SHIFT. If DATA_BITS==1, sclk rise → FULL.
  - SHIFT (0 < count < DATA_BITS): sclk rise making count==DATA_BITS → FULL.
  - FULL (count==DATA_BITS): sclk rise → OVERRUN. The sreg still shifts; the data is discarded later.
  - OVERRUN: sticky until a latch, sclrn or rst.
- Latch rise:
  - In FULL: pdata = sreg, pulse valid.
  - In IDLE, SHIFT or OVERRUN: pulse frame_err, pdata holds.
  - In every case the FSM returns to IDLE and count clears. The sreg is not cleared.
- Simultaneous sclk rise and latch rise in one cycle:
  - The shift is applied first.
  - The latch then evaluates the post-shift count and sreg.
- Simultaneous sclrn low and latch rise: the clear wins, the latch is ignored, and no pulse is issued.
- Latency: pdata, valid and frame_err update SYNC_STAGES+1 clk edges after the first clk edge that samples latch high.
- valid and frame_err are never high together and each lasts exactly 1 cycle.

Optional Feature:
- Macro: LED_S2P_INVERT_EN.
- Defined: pdata captures ~sreg, which undoes the transmitter's inversion of LED data so pdata equals the original LED word.
- Undefined: pdata captures sreg unchanged.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, SHIFT=2'd1, FULL=2'd2, OVERRUN=2'd3.
  - DIR_MSB_FIRST=0 and DIR_LSB_FIRST=1 constants.
- Sub-module sync_edge_det, instantiated once per input wire.
  - Parameter: SYNC_STAGES.
  - Ports: clk, rst, async_in, sync_out, rise.
- The top level holds the shift register, counter, FSM and output registers.

Test Plan:
- DIR 0, macro off: 16 sclk rises carrying 0xA55A MSB first, then latch → pdata=0xA55A, valid pulses exactly 1 cycle, frame_err=0.
- 15 sclk rises then latch → frame_err pulses 1 cycle, pdata holds its previous value, busy=0 after the latch.
- 17 sclk rises then latch → FSM reaches OVERRUN after the 17th rise, frame_err pulses on the latch, pdata unchanged.
- 8 bits sent, sclrn pulsed low, then full frame 0x1234 and latch → pdata=0x1234, valid pulses, no error.
- rst asserted after 10 bits, then full frame 0xFFFF and latch → all outputs 0 during reset, then pdata=0xFFFF with valid.
- Macro on: loopback from the LED P2S transmitter sending ~0x002A → pdata=0x002A. Measure latch-to-valid latency = SYNC_STAGES+1 clk edges.
